// File: rtl/fx3_vec_responder_pkg.sv
// fx3_vec_responder_pkg: shared state encoding and bus defaults for the fx3 vector responder
//   FX3_DW        default data bus width
//   FX3_RESP_KEY  default XOR key applied to the captured vector
//   fx3_state_e   responder handshake states
package fx3_vec_responder_pkg;
    localparam int FX3_DW = 23;
    localparam logic [FX3_DW-1:0] FX3_RESP_KEY = 23'h2AAAAA;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_ACK     = 2'd2,
        ST_RELEASE = 2'd3
    } fx3_state_e;
endpackage

// File: rtl/fx3_vec_responder_if.sv
// fx3_vec_responder_if: intr/ack vector handshake bus between sequencer (master) and responder (slave)
//   intr      request, vector valid while high
//   data_out  vector from initiator
//   ack       acknowledge, response valid while high
//   data_in   response vector to initiator
interface fx3_vec_responder_if #(parameter int DW = 23);
    logic          intr;
    logic [DW-1:0] data_out;
    logic          ack;
    logic [DW-1:0] data_in;
    modport master (output intr, data_out, input ack, data_in);
    modport slave (input intr, data_out, output ack, data_in);
endinterface

// File: rtl/fx3_vec_responder_sat_cnt.sv
// fx3_sat_cnt: W-bit saturating up-counter with synchronous clear taking priority over increment
//   clk/arst  clock, asynchronous active-low reset
//   clr_i     synchronous clear
//   inc_i     increment request, ignored at all-ones
//   cnt_o     counter value
module fx3_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         arst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr_i ? '0 : (inc_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk or negedge arst)
        if (!arst) cnt_q <= '0;
        else       cnt_q <= cnt_d;

    assign cnt_o = cnt_q;
endmodule

// File: rtl/fx3_vec_responder.sv
// fx3_vec_responder: responder end of the intr/ack vector handshake, answers vector ^ RESP_KEY after RESP_DLY
//   clk/arst     clock, asynchronous active-low reset
//   ena_i        gates acceptance of new requests in IDLE only
//   clr_i        synchronous clear of txn_cnt_o and proto_err_o
//   err_inj_i    (FX3_RESP_ERR_INJ_EN only) invert response bit 0 of the transaction captured this edge
//   bus          slave side of the intr/data_out/ack/data_in handshake
//   busy_o       high outside IDLE
//   txn_cnt_o    completed handshakes, saturating
//   proto_err_o  sticky: intr dropped before ack
// Optional feature macro: FX3_RESP_ERR_INJ_EN
module fx3_vec_responder
    import fx3_vec_responder_pkg::*;
#(
    parameter int              DW       = FX3_DW,
    parameter logic [DW-1:0]   RESP_KEY = FX3_RESP_KEY,
    parameter int              RESP_DLY = 4,
    parameter int              CNT_W    = 16
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              ena_i,
    input  logic              clr_i,
`ifdef FX3_RESP_ERR_INJ_EN
    input  logic              err_inj_i,
`endif
    fx3_vec_responder_if.slave bus,
    output logic              busy_o,
    output logic [CNT_W-1:0]  txn_cnt_o,
    output logic              proto_err_o
);
    localparam logic [7:0] DLY_LD = 8'(RESP_DLY);

    fx3_state_e    state_q, state_d;
    logic [7:0]    dly_q, dly_d;
    logic [DW-1:0] cap_q, cap_d;
    logic [DW-1:0] data_in_q, data_in_d;
    logic          ack_q, ack_d;
    logic          perr_q, perr_d;
    logic          accept, inc;
    logic [DW-1:0] cap_src;

`ifdef FX3_RESP_ERR_INJ_EN
    // the injected flip rides along with the captured vector
    assign cap_src = bus.data_out ^ DW'(err_inj_i);
`else
    assign cap_src = bus.data_out;
`endif

    assign accept = (state_q == ST_IDLE) && ena_i && bus.intr;

    always_ff @(posedge clk or negedge arst)
        if (!arst) state_q <= ST_IDLE;
        else       state_q <= state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    state_d = accept ? ST_WAIT : ST_IDLE;
            ST_WAIT:    state_d = !bus.intr ? ST_IDLE : (dly_q == 8'd0) ? ST_ACK : ST_WAIT;
            ST_ACK:     state_d = !bus.intr ? ST_RELEASE : ST_ACK;
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cap_d     = accept ? cap_src : cap_q;
        dly_d     = accept ? DLY_LD
                  : (state_q == ST_WAIT && bus.intr && dly_q != 8'd0) ? dly_q - 8'd1 : dly_q;
        ack_d     = (state_d == ST_ACK);
        // response is formed once on WAIT->ACK; data_out changes during ACK never reach it
        data_in_d = (state_q == ST_WAIT && state_d == ST_ACK) ? cap_q ^ RESP_KEY : data_in_q;
        // a same-edge violation beats clr so no error is ever lost
        perr_d    = (state_q == ST_WAIT && !bus.intr) ? 1'b1 : clr_i ? 1'b0 : perr_q;
        inc       = (state_q == ST_ACK) && !bus.intr;
    end

    always_ff @(posedge clk or negedge arst)
        if (!arst) begin
            dly_q     <= '0;
            cap_q     <= '0;
            data_in_q <= '0;
            ack_q     <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            dly_q     <= dly_d;
            cap_q     <= cap_d;
            data_in_q <= data_in_d;
            ack_q     <= ack_d;
            perr_q    <= perr_d;
        end

    fx3_sat_cnt #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .arst  (arst),
        .clr_i (clr_i),
        .inc_i (inc),
        .cnt_o (txn_cnt_o)
    );

    assign bus.ack     = ack_q;
    assign bus.data_in = data_in_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign proto_err_o = perr_q;
endmodule
